// File: rtl/cache_line_refill.sv
// Miss handler for a direct-mapped cache: invalidate the line, burst-refill it, then commit the tag.
// Define CACHE_REFILL_CWF_EN for a critical-word-first refill (wrapping burst from the missed word).
module cache_line_refill #(
  parameter int WORD_NUM  = 32,
  parameter int DATA_WID  = 64,
  parameter int INDEX_WID = 10,
  parameter int TAG_WID   = 14
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        miss_valid_i,
  input  logic [31:0]                 miss_addr_i,
  output logic                        miss_ready_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [31:0]                 mem_req_addr_o,
  output logic [7:0]                  mem_req_len_o,
  input  logic                        mem_rvalid_i,
  input  logic [DATA_WID-1:0]         mem_rdata_i,
  input  logic                        mem_rlast_i,
  input  logic                        mem_rerr_i,
  output logic                        fill_we_o,
  output logic [INDEX_WID-1:0]        fill_index_o,
  output logic [$clog2(WORD_NUM)-1:0] fill_word_o,
  output logic [DATA_WID-1:0]         fill_data_o,
  output logic                        tag_we_o,
  output logic [TAG_WID:0]            tag_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int WORD_W   = $clog2(WORD_NUM);
  localparam int BYTE_W   = $clog2(DATA_WID / 8);
  localparam int LINE_OFF = BYTE_W + WORD_W;
  localparam int TAG_LSB  = LINE_OFF + INDEX_WID;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INVAL  = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] beat_q, beat_d;

  logic [WORD_W-1:0] start_word;
  logic [31:0]       req_addr;
  logic              unused_addr;
  logic              last_idx;
  logic              beat_bad;

`ifdef CACHE_REFILL_CWF_EN
  assign start_word  = addr_q[BYTE_W +: WORD_W];
  assign req_addr    = {addr_q[31:BYTE_W], {BYTE_W{1'b0}}};
  assign unused_addr = ^addr_q[BYTE_W-1:0];
`else
  assign start_word  = '0;
  assign req_addr    = {addr_q[31:LINE_OFF], {LINE_OFF{1'b0}}};
  assign unused_addr = ^addr_q[LINE_OFF-1:0];
`endif

  // A beat is bad on rerr, on rlast anywhere but the final slot, or on a final slot lacking rlast.
  assign last_idx = (beat_q == WORD_W'(WORD_NUM - 1));
  assign beat_bad = mem_rerr_i | (mem_rlast_i ^ last_idx);

  assign miss_ready_o    = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = mem_req_valid_o ? req_addr : '0;
  assign mem_req_len_o   = mem_req_valid_o ? 8'(WORD_NUM - 1) : '0;
  assign fill_index_o    = addr_q[LINE_OFF +: INDEX_WID];
  assign tag_we_o        = (state_q == S_INVAL) || (state_q == S_COMMIT);
  assign tag_o           = tag_we_o ? {(state_q == S_COMMIT), addr_q[TAG_LSB +: TAG_WID]} : '0;
  assign done_o          = (state_q == S_COMMIT);
  assign fill_we_o       = (state_q == S_FILL) && mem_rvalid_i && !beat_bad;
  assign fill_word_o     = fill_we_o ? (start_word + beat_q) : '0;
  assign fill_data_o     = fill_we_o ? mem_rdata_i : '0;
  assign err_o           = mem_rvalid_i && mem_rlast_i &&
                           (((state_q == S_FILL) && beat_bad) || (state_q == S_DRAIN));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (miss_valid_i) begin
          addr_d  = miss_addr_i;
          beat_d  = '0;
          state_d = S_INVAL;
        end
      end
      S_INVAL: state_d = S_REQ;
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_rvalid_i) begin
          beat_d = beat_q + WORD_W'(1);
          if (beat_bad) state_d = mem_rlast_i ? S_IDLE : S_DRAIN;
          else if (last_idx) state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_DRAIN: begin
        if (mem_rvalid_i && mem_rlast_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_cache_line_refill.sv
// Randomized self-checking bench for cache_line_refill against a beat-list reference model.
// Honours CACHE_REFILL_CWF_EN the same way the design does.
module tb_cache_line_refill;
  localparam int WORD_NUM  = 32;
  localparam int DATA_WID  = 64;
  localparam int INDEX_WID = 10;
  localparam int TAG_WID   = 14;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 miss_valid_i;
  logic [31:0]          miss_addr_i;
  logic                 miss_ready_o;
  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i;
  logic [31:0]          mem_req_addr_o;
  logic [7:0]           mem_req_len_o;
  logic                 mem_rvalid_i;
  logic [DATA_WID-1:0]  mem_rdata_i;
  logic                 mem_rlast_i;
  logic                 mem_rerr_i;
  logic                 fill_we_o;
  logic [INDEX_WID-1:0] fill_index_o;
  logic [4:0]           fill_word_o;
  logic [DATA_WID-1:0]  fill_data_o;
  logic                 tag_we_o;
  logic [TAG_WID:0]     tag_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  always #5 clk_i = ~clk_i;

  cache_line_refill dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_len_o(mem_req_len_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rlast_i(mem_rlast_i), .mem_rerr_i(mem_rerr_i),
    .fill_we_o(fill_we_o), .fill_index_o(fill_index_o), .fill_word_o(fill_word_o),
    .fill_data_o(fill_data_o), .tag_we_o(tag_we_o), .tag_o(tag_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  logic [DATA_WID-1:0] beat_data [0:63];

  int                  got_w[$];
  logic [DATA_WID-1:0] got_d[$];
  logic [TAG_WID:0]    got_tag[$];
  logic [INDEX_WID-1:0] got_tidx[$];
  int cyc = 0, done_cnt, err_cnt, done_cyc, err_cyc, last_cyc, acc_cyc;

  int                  exp_w[$];
  logic [DATA_WID-1:0] exp_d[$];
  logic [TAG_WID:0]    exp_tag[$];
  logic [INDEX_WID-1:0] exp_idx;
  int exp_done, exp_err;

  bit acc_ok, req_found, req_stable, req_ready_seen;
  logic [31:0] req_a;
  logic [7:0]  req_l;

  // Observe every cycle between edges; reset cycles are not part of any transaction.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (miss_valid_i && miss_ready_o) acc_cyc = cyc;
      if (fill_we_o) begin got_w.push_back(int'(fill_word_o)); got_d.push_back(fill_data_o); end
      if (tag_we_o) begin got_tag.push_back(tag_o); got_tidx.push_back(fill_index_o); end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (err_o) begin err_cnt++; err_cyc = cyc; end
      if (mem_rvalid_i && mem_rlast_i) last_cyc = cyc;
    end
    cyc++;
  end

  function automatic int start_of(input logic [31:0] a);
`ifdef CACHE_REFILL_CWF_EN
    return int'(a[7:3]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] req_of(input logic [31:0] a);
`ifdef CACHE_REFILL_CWF_EN
    return {a[31:3], 3'b000};
`else
    return {a[31:8], 8'h00};
`endif
  endfunction

  task automatic clear_mon();
    got_w.delete(); got_d.delete(); got_tag.delete(); got_tidx.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -100; err_cyc = -100; last_cyc = -100; acc_cyc = -100;
  endtask

  // Walks the beat list the memory will return and predicts writes, tags and outcome.
  task automatic build_expect(input logic [31:0] addr, input int err_beat, input int last_beat);
    int start = start_of(addr);
    exp_w.delete(); exp_d.delete(); exp_tag.delete();
    exp_done = 0; exp_err = 0;
    exp_idx = addr[17:8];
    exp_tag.push_back({1'b0, addr[31:18]});
    for (int k = 0; k <= last_beat; k++) begin
      if (k == err_beat || (k == last_beat && k != WORD_NUM - 1) ||
          (k == WORD_NUM - 1 && k != last_beat)) begin
        exp_err = 1;
        break;
      end
      exp_w.push_back((start + k) % WORD_NUM);
      exp_d.push_back(beat_data[k]);
      if (k == WORD_NUM - 1) exp_done = 1;
    end
    if (exp_done == 1) exp_tag.push_back({1'b1, addr[31:18]});
  endtask

  task automatic start_miss(input logic [31:0] addr);
    int n = 0;
    miss_valid_i = 1'b1;
    miss_addr_i  = addr;
    @(negedge clk_i);
    while (!miss_ready_o && n < 20) begin @(negedge clk_i); n++; end
    acc_ok = miss_ready_o;
    @(posedge clk_i); #1;
    miss_valid_i = 1'b0;
    miss_addr_i  = $urandom;
  endtask

  task automatic do_req(input int delay, input bit busy_miss);
    int n = 0;
    req_stable = 1; req_ready_seen = 0;
    if (busy_miss) begin miss_valid_i = 1'b1; miss_addr_i = 32'hDEAD_BEE8; end
    @(negedge clk_i);
    while (!mem_req_valid_o && n < 10) begin @(negedge clk_i); n++; end
    req_found = mem_req_valid_o; req_a = mem_req_addr_o; req_l = mem_req_len_o;
    for (int i = 0; i < delay; i++) begin
      if (miss_ready_o) req_ready_seen = 1;
      @(negedge clk_i);
      if (!mem_req_valid_o || mem_req_addr_o !== req_a || mem_req_len_o !== req_l) req_stable = 0;
    end
    if (miss_ready_o) req_ready_seen = 1;
    mem_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_req_ready_i = 1'b0;
    miss_valid_i = 1'b0;
  endtask

  task automatic drive_beats(input int n, input int last_beat, input int err_beat, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        int idle = $urandom_range(0, 2);
        repeat (idle) begin
          mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; mem_rerr_i = 1'b0;
          @(posedge clk_i); #1;
        end
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = beat_data[k];
      mem_rlast_i  = (k == last_beat);
      mem_rerr_i   = (k == err_beat);
      @(posedge clk_i); #1;
    end
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; mem_rerr_i = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input int err_beat, input int last_beat,
                         input int delay, input bit gaps, input bit busy_miss);
    clear_mon();
    build_expect(addr, err_beat, last_beat);
    start_miss(addr);
    do_req(delay, busy_miss);
    drive_beats(last_beat + 1, last_beat, err_beat, gaps);
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = $urandom; mem_rlast_i = $urandom; mem_rerr_i = $urandom;
      mem_rdata_i = {$urandom, $urandom};
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
    clear_mon();
    @(negedge clk_i);
    checks++;
    if (miss_ready_o !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got %b exp 1", miss_ready_o);
    end
    checks++;
    if ((|{busy_o, mem_req_valid_o, mem_req_addr_o, mem_req_len_o, fill_we_o, fill_index_o,
           fill_word_o, fill_data_o, tag_we_o, tag_o, done_o, err_o}) !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got busy=%b req=%b addr=%h len=%h we=%b data=%h tag_we=%b tag=%h done=%b err=%b exp all 0",
               busy_o, mem_req_valid_o, mem_req_addr_o, mem_req_len_o, fill_we_o, fill_data_o,
               tag_we_o, tag_o, done_o, err_o);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1'b1; mem_rlast_i = (i == 2); mem_rerr_i = 1'b0;
      mem_rdata_i = {$urandom, $urandom};
      @(posedge clk_i); #1;
    end
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (got_w.size() != 0 || err_cnt != 0 || done_cnt != 0 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stale_beats got writes=%0d err=%0d done=%0d busy=%b exp 0/0/0/0",
               got_w.size(), err_cnt, done_cnt, busy_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_clean_fill();
    for (int k = 0; k < 64; k++) beat_data[k] = DATA_WID'(k);
    run_txn(32'h1234_5678, -1, 31, 0, 0, 0);
    checks++;
    if (!acc_ok || !req_found || req_a !== req_of(32'h1234_5678) || req_l !== 8'd31) begin
      failures++;
      $display("[TB] FAIL clean_req got acc=%b found=%b addr=%h len=%0d exp addr=%h len=31",
               acc_ok, req_found, req_a, req_l, req_of(32'h1234_5678));
    end
    checks++;
    if (got_tag.size() != 2) begin
      failures++; $display("[TB] FAIL clean_tag_count got %0d exp 2", got_tag.size());
    end else begin
      checks++;
      if (got_tag[0] !== 15'h048D || got_tidx[0] !== 10'h056) begin
        failures++;
        $display("[TB] FAIL clean_inval got %h idx %h exp 048d idx 056", got_tag[0], got_tidx[0]);
      end
      checks++;
      if (got_tag[1] !== 15'h448D || got_tidx[1] !== 10'h056) begin
        failures++;
        $display("[TB] FAIL clean_commit got %h idx %h exp 448d idx 056", got_tag[1], got_tidx[1]);
      end
    end
    checks++;
    if (got_w.size() != 32) begin
      failures++; $display("[TB] FAIL clean_write_count got %0d exp 32", got_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_d[i] !== exp_d[i]) begin
        failures++;
        $display("[TB] FAIL clean_write%0d got w%0d d=%h exp w%0d d=%h", i, got_w[i], got_d[i], exp_w[i], exp_d[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0 || done_cyc - acc_cyc + 1 != WORD_NUM + 4) begin
      failures++;
      $display("[TB] FAIL clean_done got done=%0d err=%0d latency=%0d exp 1/0/%0d",
               done_cnt, err_cnt, done_cyc - acc_cyc + 1, WORD_NUM + 4);
    end
  endtask

  task automatic test_errors();
    int err_tab[4]  = '{10, -1, -1, 20};
    int last_tab[4] = '{31,  5, 33, 20};
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 64; k++) beat_data[k] = {$urandom, $urandom};
      run_txn({$urandom} & 32'hFFFF_FFF8, err_tab[t], last_tab[t], 0, 0, 0);
      checks++;
      if (got_w.size() != exp_w.size()) begin
        failures++; $display("[TB] FAIL err%0d_write_count got %0d exp %0d", t, got_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
        checks++;
        if (got_w[i] !== exp_w[i] || got_d[i] !== exp_d[i]) begin
          failures++;
          $display("[TB] FAIL err%0d_write%0d got w%0d d=%h exp w%0d d=%h", t, i, got_w[i], got_d[i], exp_w[i], exp_d[i]);
        end
      end
      checks++;
      if (got_tag.size() != 1 || got_tag[0] !== exp_tag[0] || got_tidx[0] !== exp_idx) begin
        failures++;
        $display("[TB] FAIL err%0d_tag got count=%0d first=%h exp count=1 first=%h", t, got_tag.size(),
                 (got_tag.size() > 0) ? got_tag[0] : '0, exp_tag[0]);
      end
      checks++;
      if (err_cnt != 1 || done_cnt != 0 || err_cyc != last_cyc) begin
        failures++;
        $display("[TB] FAIL err%0d_pulse got err=%0d done=%0d at %0d exp err=1 done=0 at rlast %0d",
                 t, err_cnt, done_cnt, err_cyc, last_cyc);
      end
    end
  endtask

  task automatic test_req_stall();
    logic [31:0] addr = 32'h8765_4321;
    for (int k = 0; k < 64; k++) beat_data[k] = {$urandom, $urandom};
    run_txn(addr, -1, 31, 7, 0, 1);
    checks++;
    if (!req_found || !req_stable || req_a !== req_of(addr) || req_l !== 8'd31) begin
      failures++;
      $display("[TB] FAIL stall_req got found=%b stable=%b addr=%h len=%0d exp 1/1/%h/31",
               req_found, req_stable, req_a, req_l, req_of(addr));
    end
    checks++;
    if (req_ready_seen) begin
      failures++; $display("[TB] FAIL stall_busy_ready got miss_ready=1 while busy exp 0");
    end
    checks++;
    if (got_tag.size() != 2 || got_w.size() != 32 || done_cnt != 1 || err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL stall_outcome got tags=%0d writes=%0d done=%0d err=%0d exp 2/32/1/0",
               got_tag.size(), got_w.size(), done_cnt, err_cnt);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [31:0] addr = $urandom;
      int kind = $urandom_range(0, 3);
      int eb = -1;
      int lb = 31;
      if (kind == 1) begin eb = $urandom_range(0, 31); lb = 31 + $urandom_range(0, 2); end
      else if (kind == 2) lb = $urandom_range(0, 30);
      else if (kind == 3) lb = $urandom_range(32, 35);
      for (int k = 0; k < 64; k++) beat_data[k] = {$urandom, $urandom};
      run_txn(addr, eb, lb, $urandom_range(0, 3), 1, 1'($urandom));
      checks++;
      if (!acc_ok || req_a !== req_of(addr) || got_w.size() != exp_w.size()) begin
        failures++;
        $display("[TB] FAIL rnd%0d_shape got acc=%b addr=%h writes=%0d exp 1/%h/%0d", t, acc_ok,
                 req_a, got_w.size(), req_of(addr), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
        checks++;
        if (got_w[i] !== exp_w[i] || got_d[i] !== exp_d[i]) begin
          failures++;
          $display("[TB] FAIL rnd%0d_write%0d got w%0d d=%h exp w%0d d=%h", t, i, got_w[i], got_d[i], exp_w[i], exp_d[i]);
        end
      end
      checks++;
      if (got_tag.size() != exp_tag.size() || got_tag[got_tag.size()-1] !== exp_tag[exp_tag.size()-1]) begin
        failures++;
        $display("[TB] FAIL rnd%0d_tag got count=%0d exp count=%0d last=%h", t, got_tag.size(),
                 exp_tag.size(), exp_tag[exp_tag.size()-1]);
      end
      checks++;
      if (done_cnt != exp_done || err_cnt != exp_err ||
          (exp_err == 1 && err_cyc != last_cyc) || (exp_done == 1 && done_cyc != last_cyc + 1)) begin
        failures++;
        $display("[TB] FAIL rnd%0d_outcome got done=%0d err=%0d exp done=%0d err=%0d", t, done_cnt,
                 err_cnt, exp_done, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 64; k++) beat_data[k] = {$urandom, $urandom};
    clear_mon();
    start_miss(32'h0F0F_0F00);
    do_req(0, 0);
    drive_beats(12, -1, -1, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = beat_data[12]; mem_rlast_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mem_rlast_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (miss_ready_o !== 1'b1 || busy_o !== 1'b0 || fill_we_o !== 1'b0 || fill_index_o !== '0 ||
        tag_we_o !== 1'b0 || err_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got ready=%b busy=%b we=%b idx=%h tag_we=%b err=%b done=%b exp 1/0/0/0/0/0/0",
               miss_ready_o, busy_o, fill_we_o, fill_index_o, tag_we_o, err_o, done_o);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1'b1; mem_rlast_i = 1'($urandom); mem_rdata_i = {$urandom, $urandom};
      @(posedge clk_i); #1;
    end
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (got_w.size() != 12 || got_tag.size() != 1 || done_cnt != 0 || err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL midreset_after got writes=%0d tags=%0d done=%0d err=%0d exp 12/1/0/0",
               got_w.size(), got_tag.size(), done_cnt, err_cnt);
    end
  endtask

  initial begin
    rst_i = 1'b1; miss_valid_i = 1'b0; miss_addr_i = '0; mem_req_ready_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rlast_i = 1'b0; mem_rerr_i = 1'b0;
    test_reset();
    test_clean_fill();
    test_errors();
    test_req_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
